// File: rtl/reconfig_if.sv
// Bus between the reconfiguration controller and its UART / datapath / trace-buffer
// neighbours. master = controller side, slave = environment side.
interface reconfig_if #(
    parameter int CFG_DATA_W = 16,
    parameter int TB_W       = 32,
    parameter int TB_ADDR_W  = 4
);
    logic [7:0]            rx_data;
    logic                  new_rx_data;
    logic [7:0]            tx_data;
    logic                  new_tx_data;
    logic                  tx_busy;
    logic                  tracing;
    logic [7:0]            configId;
    logic [CFG_DATA_W-1:0] configData;
    logic                  config_valid;
    logic                  tb_rd_en;
    logic [TB_ADDR_W-1:0]  tb_rd_addr;
    logic [TB_W-1:0]       tb_rd_data;

    modport master (
        input  rx_data, new_rx_data, tx_busy, tb_rd_data,
        output tx_data, new_tx_data, tracing, configId, configData, config_valid,
               tb_rd_en, tb_rd_addr
    );

    modport slave (
        output rx_data, new_rx_data, tx_busy, tb_rd_data,
        input  tx_data, new_tx_data, tracing, configId, configData, config_valid,
               tb_rd_en, tb_rd_addr
    );
endinterface

// File: rtl/reconfig_controller.sv
// UART command decoder: CONFIG / START / STOP / DUMP of the trace buffer.
// Define RECONFIG_ACK_EN to echo the opcode byte after CONFIG, START and STOP.
module reconfig_controller #(
    parameter int CFG_DATA_W = 16,
    parameter int TB_W       = 32,
    parameter int TB_ADDR_W  = 4
) (
    input  logic        clk,
    input  logic        reset,
    reconfig_if.master  bus
);
    localparam logic [7:0] OP_CONFIG = 8'h01;
    localparam logic [7:0] OP_START  = 8'h02;
    localparam logic [7:0] OP_STOP   = 8'h03;
    localparam logic [7:0] OP_DUMP   = 8'h04;
    localparam logic [7:0] CFG_LAST  = 8'(CFG_DATA_W / 8 - 1);
    localparam logic [7:0] TB_LAST   = 8'(TB_W / 8 - 1);

    typedef enum logic [2:0] {
        IDLE, GET_ID, GET_DATA, DUMP_RD, DUMP_LATCH, DUMP_TX
`ifdef RECONFIG_ACK_EN
        , ACK
`endif
    } state_t;

    state_t                state_q, state_d;
    logic                  tracing_q, tracing_d;
    logic [7:0]            cfg_id_q, cfg_id_d;
    logic [CFG_DATA_W-1:0] cfg_data_q, cfg_data_d;
    logic                  cfg_valid_q, cfg_valid_d;
    logic [CFG_DATA_W-1:0] cfg_shift_q, cfg_shift_d;
    logic [7:0]            id_q, id_d;
    logic [7:0]            tx_data_q, tx_data_d;
    logic                  new_tx_q, new_tx_d;
    logic                  rd_en_q, rd_en_d;
    logic [TB_ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [TB_W-1:0]       word_q, word_d;
    logic [7:0]            byte_cnt_q, byte_cnt_d;
`ifdef RECONFIG_ACK_EN
    logic [7:0]            op_q, op_d;
`endif

    // A byte may only be launched if the UART is idle and no strobe is in flight.
    logic tx_ready;
    assign tx_ready = !bus.tx_busy && !new_tx_q;

    always_comb begin
        state_d     = state_q;
        tracing_d   = tracing_q;
        cfg_id_d    = cfg_id_q;
        cfg_data_d  = cfg_data_q;
        cfg_valid_d = 1'b0;
        cfg_shift_d = cfg_shift_q;
        id_d        = id_q;
        tx_data_d   = tx_data_q;
        new_tx_d    = 1'b0;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        word_d      = word_q;
        byte_cnt_d  = byte_cnt_q;
`ifdef RECONFIG_ACK_EN
        op_d        = op_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.new_rx_data) begin
                    case (bus.rx_data)
                        OP_CONFIG: state_d = GET_ID;
                        OP_START: begin
                            tracing_d = 1'b1;
`ifdef RECONFIG_ACK_EN
                            op_d    = OP_START;
                            state_d = ACK;
`endif
                        end
                        OP_STOP: begin
                            tracing_d = 1'b0;
`ifdef RECONFIG_ACK_EN
                            op_d    = OP_STOP;
                            state_d = ACK;
`endif
                        end
                        OP_DUMP: begin
                            tracing_d = 1'b0;
                            rd_addr_d = '0;
                            rd_en_d   = 1'b1;
                            state_d   = DUMP_RD;
                        end
                        default: ;
                    endcase
                end
            end
            GET_ID: begin
                if (bus.new_rx_data) begin
                    id_d       = bus.rx_data;
                    byte_cnt_d = '0;
                    state_d    = GET_DATA;
                end
            end
            GET_DATA: begin
                if (bus.new_rx_data) begin
                    cfg_shift_d = (cfg_shift_q << 8) | CFG_DATA_W'(bus.rx_data);
                    if (byte_cnt_q == CFG_LAST) begin
                        cfg_id_d    = id_q;
                        cfg_data_d  = cfg_shift_d;
                        cfg_valid_d = 1'b1;
                        byte_cnt_d  = '0;
`ifdef RECONFIG_ACK_EN
                        op_d    = OP_CONFIG;
                        state_d = ACK;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
            DUMP_RD: state_d = DUMP_LATCH;
            DUMP_LATCH: begin
                word_d     = bus.tb_rd_data;
                byte_cnt_d = '0;
                state_d    = DUMP_TX;
            end
            DUMP_TX: begin
                if (tx_ready) begin
                    tx_data_d = word_q[TB_W-1 -: 8];
                    new_tx_d  = 1'b1;
                    word_d    = word_q << 8;
                    if (byte_cnt_q == TB_LAST) begin
                        byte_cnt_d = '0;
                        // Stop at the last address instead of letting the counter wrap.
                        if (&rd_addr_q) begin
                            state_d = IDLE;
                        end else begin
                            rd_addr_d = rd_addr_q + TB_ADDR_W'(1);
                            rd_en_d   = 1'b1;
                            state_d   = DUMP_RD;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 8'd1;
                    end
                end
            end
`ifdef RECONFIG_ACK_EN
            ACK: begin
                if (tx_ready) begin
                    tx_data_d = op_q;
                    new_tx_d  = 1'b1;
                    state_d   = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tracing_q   <= 1'b0;
            cfg_id_q    <= '0;
            cfg_data_q  <= '0;
            cfg_valid_q <= 1'b0;
            cfg_shift_q <= '0;
            id_q        <= '0;
            tx_data_q   <= '0;
            new_tx_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            word_q      <= '0;
            byte_cnt_q  <= '0;
`ifdef RECONFIG_ACK_EN
            op_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            tracing_q   <= tracing_d;
            cfg_id_q    <= cfg_id_d;
            cfg_data_q  <= cfg_data_d;
            cfg_valid_q <= cfg_valid_d;
            cfg_shift_q <= cfg_shift_d;
            id_q        <= id_d;
            tx_data_q   <= tx_data_d;
            new_tx_q    <= new_tx_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            word_q      <= word_d;
            byte_cnt_q  <= byte_cnt_d;
`ifdef RECONFIG_ACK_EN
            op_q        <= op_d;
`endif
        end
    end

    assign bus.tracing      = tracing_q;
    assign bus.configId     = cfg_id_q;
    assign bus.configData   = cfg_data_q;
    assign bus.config_valid = cfg_valid_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.new_tx_data  = new_tx_q;
    assign bus.tb_rd_en     = rd_en_q;
    assign bus.tb_rd_addr   = rd_addr_q;
endmodule

// File: tb/tb_reconfig_controller.sv
// Randomized self-checking bench for reconfig_controller with a command-level reference model.
module tb_reconfig_controller;
    localparam int CFG_DATA_W = 16;
    localparam int TB_W       = 32;
    localparam int TB_ADDR_W  = 4;
    localparam int DEPTH      = 1 << TB_ADDR_W;
`ifdef RECONFIG_ACK_EN
    localparam int ACK = 1;
`else
    localparam int ACK = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    reconfig_if #(.CFG_DATA_W(CFG_DATA_W), .TB_W(TB_W), .TB_ADDR_W(TB_ADDR_W)) bus ();

    reconfig_controller #(.CFG_DATA_W(CFG_DATA_W), .TB_W(TB_W), .TB_ADDR_W(TB_ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [TB_W-1:0] tb_mem [DEPTH];
    logic [7:0] tx_q [$];
    int cv_cnt = 0;
    int rd_cnt = 0;
    int hs_viol = 0;
    int busy_len = 0;
    int busy_cnt = 0;
    logic prev_ntx = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Trace buffer: one-cycle read latency.
    always @(posedge clk) begin
        if (bus.tb_rd_en) bus.tb_rd_data <= tb_mem[bus.tb_rd_addr];
    end

    // UART transmitter model and event monitor.
    always @(negedge clk) begin
        if (reset) begin
            busy_cnt = 0;
            prev_ntx = 1'b0;
            bus.tx_busy = 1'b0;
        end else begin
            if (bus.config_valid) cv_cnt++;
            if (bus.tb_rd_en) rd_cnt++;
            if (bus.new_tx_data) begin
                if (prev_ntx || bus.tx_busy) hs_viol++;
                tx_q.push_back(bus.tx_data);
                busy_cnt = busy_len;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            prev_ntx = bus.new_tx_data;
            bus.tx_busy = (busy_cnt > 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_data = b;
        bus.new_rx_data = 1'b1;
        @(negedge clk);
        bus.new_rx_data = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_tracing", bus.tracing, 0);
        chk("rst_cfg_id", bus.configId, 0);
        chk("rst_cfg_data", bus.configData, 0);
        chk("rst_cfg_valid", bus.config_valid, 0);
        chk("rst_new_tx", bus.new_tx_data, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_rd_en", bus.tb_rd_en, 0);
        chk("rst_rd_addr", bus.tb_rd_addr, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_dump(input string tag);
        int cyc;
        int rd0;
        logic [TB_W-1:0] w;
        logic [7:0] id0;
        id0 = bus.configId;
        tx_q.delete();
        rd0 = rd_cnt;
        send_byte(8'h04);
        chk({tag, "_tracing_clr"}, bus.tracing, 0);
        // Commands arriving mid-dump must have no effect.
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h09);
        cyc = 0;
        while (tx_q.size() < DEPTH * TB_W / 8 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        idle(busy_len + 10);
        chk({tag, "_nbytes"}, tx_q.size(), DEPTH * TB_W / 8);
        for (int a = 0; a < DEPTH; a++) begin
            w = 32'hA0B0C0D0 + a;
            for (int k = 0; k < TB_W / 8; k++) begin
                if (a * (TB_W / 8) + k < tx_q.size())
                    chk($sformatf("%s_byte%0d", tag, a * (TB_W / 8) + k),
                        tx_q[a * (TB_W / 8) + k], w[TB_W-1-8*k -: 8]);
            end
        end
        chk({tag, "_rd_pulses"}, rd_cnt - rd0, DEPTH);
        chk({tag, "_tracing_end"}, bus.tracing, 0);
        chk({tag, "_cfg_id_kept"}, bus.configId, id0);
    endtask

    logic m_tr;
    logic [7:0] m_id;
    logic [CFG_DATA_W-1:0] m_data;
    logic [7:0] exp_tx [$];

    initial begin
        int c0;
        int k;
        logic [7:0] b;
        bus.rx_data = 8'h00;
        bus.new_rx_data = 1'b0;
        for (int a = 0; a < DEPTH; a++) tb_mem[a] = 32'hA0B0C0D0 + a;

        #1;
        check_reset_vals();
        idle(3);
        reset = 1'b0;
        idle(2);

        // CONFIG 0x05 <- 0xBEEF
        c0 = cv_cnt;
        tx_q.delete();
        send_byte(8'h01); send_byte(8'h05); send_byte(8'hBE); send_byte(8'hEF);
        chk("cfg_valid_now", bus.config_valid, 1);
        idle(6);
        chk("cfg_valid_once", cv_cnt - c0, 1);
        chk("cfg_id", bus.configId, 8'h05);
        chk("cfg_data", bus.configData, 16'hBEEF);
        chk("cfg_tracing", bus.tracing, 0);
        chk("cfg_ack_n", tx_q.size(), ACK);
        if (tx_q.size() > 0) chk("cfg_ack_byte", tx_q[0], 8'h01);

        // START / junk / STOP
        tx_q.delete();
        send_byte(8'h02);
        chk("start_tracing", bus.tracing, 1);
        idle(6);
        chk("start_ack_n", tx_q.size(), ACK);
        if (tx_q.size() > 0) chk("start_ack_byte", tx_q[0], 8'h02);
        send_byte(8'h7F);
        chk("junk_tracing", bus.tracing, 1);
        idle(6);
        chk("junk_no_tx", tx_q.size(), ACK);
        send_byte(8'h03);
        chk("stop_tracing", bus.tracing, 0);
        idle(6);
        chk("cfg_id_hold", bus.configId, 8'h05);
        chk("cfg_data_hold", bus.configData, 16'hBEEF);

        // DUMP with an idle UART, then with a slow one
        send_byte(8'h02);
        idle(6);
        run_dump("dump_fast");
        busy_len = 50;
        send_byte(8'h02);
        idle(60);
        run_dump("dump_slow");
        busy_len = 0;
        idle(10);

        // Reset in the middle of a CONFIG
        send_byte(8'h01); send_byte(8'h05); send_byte(8'hBE);
        c0 = cv_cnt;
        tx_q.delete();
        do_reset();
        idle(5);
        chk("rst_no_cfg_pulse", cv_cnt - c0, 0);
        chk("rst_no_tx", tx_q.size(), 0);
        send_byte(8'h01); send_byte(8'h06); send_byte(8'h12); send_byte(8'h34);
        idle(6);
        chk("post_rst_cfg_id", bus.configId, 8'h06);
        chk("post_rst_cfg_data", bus.configData, 16'h1234);
        chk("post_rst_cfg_once", cv_cnt - c0, 1);

        // Random command stream against the reference model
        idle(6);
        m_tr = bus.tracing;
        m_id = 8'h06;
        m_data = 16'h1234;
        tx_q.delete();
        exp_tx.delete();
        for (int i = 0; i < 40; i++) begin
            busy_len = $urandom_range(0, 3);
            c0 = cv_cnt;
            k = $urandom_range(0, 3);
            case (k)
                0: begin
                    m_id = 8'($urandom);
                    m_data = CFG_DATA_W'($urandom);
                    send_byte(8'h01);
                    idle($urandom_range(0, 2));
                    send_byte(m_id);
                    for (int j = CFG_DATA_W / 8 - 1; j >= 0; j--) begin
                        idle($urandom_range(0, 2));
                        send_byte(m_data[8*j +: 8]);
                    end
                    if (ACK != 0) exp_tx.push_back(8'h01);
                end
                1: begin
                    send_byte(8'h02);
                    m_tr = 1'b1;
                    if (ACK != 0) exp_tx.push_back(8'h02);
                end
                2: begin
                    send_byte(8'h03);
                    m_tr = 1'b0;
                    if (ACK != 0) exp_tx.push_back(8'h03);
                end
                default: begin
                    b = 8'($urandom_range(5, 255));
                    send_byte(b);
                end
            endcase
            idle(12);
            chk($sformatf("rnd%0d_tracing", i), bus.tracing, m_tr);
            chk($sformatf("rnd%0d_cfg_id", i), bus.configId, m_id);
            chk($sformatf("rnd%0d_cfg_data", i), bus.configData, m_data);
            chk($sformatf("rnd%0d_cfg_pulses", i), cv_cnt - c0, (k == 0) ? 1 : 0);
        end
        chk("rnd_tx_n", tx_q.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i < tx_q.size()) chk($sformatf("rnd_tx%0d", i), tx_q[i], exp_tx[i]);
        end
        chk("tx_handshake", hs_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/reconfig_controller.md
RECONFIG_CONTROLLER -- requirements
Module: reconfig_controller

Interface
REQ-001 Parameter CFG_DATA_W, default 16: config data width; SHALL be a multiple of 8 (8..64).
REQ-002 Parameter TB_W, default 32: trace buffer word width; SHALL be a multiple of 8 (8..128).
REQ-003 Parameter TB_ADDR_W, default 4: trace buffer address width; depth = 2**TB_ADDR_W.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_data  input  8  received UART byte.
REQ-007 new_rx_data  input  1  one-cycle strobe, rx_data valid.
REQ-008 tx_data  output  8  byte to transmit.
REQ-009 new_tx_data  output  1  one-cycle transmit strobe.
REQ-010 tx_busy  input  1  UART transmitter busy.
REQ-011 tracing  output  1  trace enable to datapath blocks.
REQ-012 configId  output  8  target block id.
REQ-013 configData  output  CFG_DATA_W  configuration payload.
REQ-014 config_valid  output  1  one-cycle strobe, configId/configData valid.
REQ-015 tb_rd_en  output  1  trace buffer read request.
REQ-016 tb_rd_addr  output  TB_ADDR_W  trace buffer read address.
REQ-017 tb_rd_data  input  TB_W  read data, valid exactly one cycle after tb_rd_en.

Function
REQ-018 Opcodes (first byte of a command): 0x01 CONFIG, 0x02 START, 0x03 STOP, 0x04 DUMP; any other byte in IDLE SHALL be discarded with no output effect.
REQ-019 States: IDLE, GET_ID, GET_DATA, DUMP_RD, DUMP_LATCH, DUMP_TX, ACK.
REQ-020 CONFIG: IDLE->GET_ID; next rx byte -> id; GET_DATA collects CFG_DATA_W/8 bytes MSB-first; on the last byte's strobe cycle +1, configId/configData SHALL update and config_valid SHALL pulse one cycle; then IDLE (or ACK).
REQ-021 configId/configData SHALL hold their last value between commands.
REQ-022 START SHALL set tracing=1 and STOP SHALL clear it, one cycle after the opcode strobe.
REQ-023 DUMP SHALL clear tracing, then for addr 0..depth-1: DUMP_RD asserts tb_rd_en one cycle; DUMP_LATCH captures tb_rd_data; DUMP_TX sends TB_W/8 bytes MSB-first; after the last byte of addr depth-1, return to IDLE with tracing left 0.
REQ-024 tx handshake: new_tx_data SHALL pulse only when tx_busy=0 and new_tx_data was 0 the previous cycle; tx_data SHALL be stable during the pulse; no byte SHALL be dropped or repeated regardless of tx_busy duration.
REQ-025 new_rx_data strobes during any DUMP state or ACK SHALL be ignored.
REQ-026 tb_rd_addr wrap: counter is TB_ADDR_W bits; completion detected at all-ones address, never wraps to re-send address 0.
REQ-027 new_rx_data simultaneous with a pending tx in ACK: the rx byte is discarded.

Reset
REQ-028 On reset assertion, asynchronously: state=IDLE, tracing=0, configId=0, configData=0, config_valid=0, new_tx_data=0, tx_data=0, tb_rd_en=0, tb_rd_addr=0, byte counters=0.
REQ-029 Reset mid-command or mid-dump SHALL abandon it; no partial config_valid or tx pulse after deassertion.

Configuration
REQ-030 Macro RECONFIG_ACK_EN defined: after CONFIG (after config_valid), START and STOP, enter ACK and transmit one byte equal to the opcode, per REQ-024, then IDLE.
REQ-031 RECONFIG_ACK_EN undefined: ACK state absent; commands return directly to IDLE; new_tx_data asserts only during DUMP.

Verification
REQ-032 Reset, then rx 0x01,0x05,0xBE,0xEF -> configId=0x05, configData=0xBEEF, config_valid single pulse; tracing=0.
REQ-033 rx 0x02 -> tracing=1 next cycle; rx 0x7F -> no change; rx 0x03 -> tracing=0.
REQ-034 tracing=1, tb word[a]=0xA0B0C0D0+a, rx 0x04 -> tracing=0; 64 tx bytes A0,B0,C0,D0,A0,B0,C0,D1,... ending D0+15; 16 tb_rd_en pulses; rx during dump ignored.
REQ-035 During dump hold tx_busy=1 for 50 cycles after each strobe -> byte sequence identical to REQ-034, no duplicates.
REQ-036 Assert reset after 0x01,0x05,0xBE -> all outputs at reset values; then 0x01,0x06,0x12,0x34 -> configId=0x06, configData=0x1234.
REQ-037 RECONFIG_ACK_EN defined: rx 0x02 -> tracing=1 and tx byte 0x02 once; undefined -> no tx.
